// File: rtl/reg_file_mp.sv
// Parametrised register file with N read ports, zero register, bypass,
// per-port read enables and a post-reset clear sequencer.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_READ-1:0]          rd_en,
    input  logic [N_READ*ADDR_W-1:0]   rd_addr,
    output logic [N_READ*DATA_W-1:0]   rd_data,
    input  logic                       reg_write,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       init_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clrCnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] readVal [N_READ];
    logic              wrDrop;
    logic              wrFire;

    assign wrDrop = (ZERO_REG != 0) && (wr_addr == '0);
    assign wrFire = (state == RUN) && reg_write && !wrDrop;

    // Read-value priority: zero register, then bypass, then stored contents.
    always_comb begin
        for (int i = 0; i < N_READ; i++) begin
            logic [ADDR_W-1:0] addr;
            logic              zeroHit;
            logic              bypHit;
            addr    = rd_addr[i*ADDR_W +: ADDR_W];
            zeroHit = (ZERO_REG != 0) && (addr == '0);
            bypHit  = !zeroHit && (BYPASS != 0) && reg_write
                      && (wr_addr == addr);
            readVal[i] = mem[addr];
            unique case (1'b1)
                zeroHit: readVal[i] = '0;
                bypHit:  readVal[i] = wr_data;
                default: readVal[i] = mem[addr];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clrCnt    <= '0;
            init_busy <= 1'b1;
        end else if (state == CLEAR) begin
            clrCnt <= clrCnt + ADDR_W'(1);
            if (clrCnt == ADDR_W'(DEPTH - 1)) begin
                state     <= RUN;
                init_busy <= 1'b0;
            end
        end
    end

    // Storage has no reset; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clrCnt] <= '0;
            end else if (wrFire) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < N_READ; i++) begin
                if (rd_en[i]) begin
                    rd_data[i*DATA_W +: DATA_W] <= readVal[i];
                end
            end
        end
    end

endmodule
